serial_adder: RTL and testbench

Parametrised bit-serial adder/subtractor, the clocked successor to the board's combinational half/full-adder chains. It adds or subtracts two WIDTH-bit operands one bit per clock, LSB first, through a single full-adder cell and a carry register. It sits between the switch bank and the LED bank: operands come from switches, the result and flags drive LEDs. A start/busy/done handshake lets operand width grow without growing the adder cell.

---
 rtl/serial_adder.sv | 173 +++++++++++++++++
 tb/tb_serial_adder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder/subtractor, one full-adder cell plus a carry register.
// Operands are processed LSB first, one bit per clock. A start/busy/done handshake
// frames each operation.
//
// Parameters:
//   WIDTH      operand/result width in bits (2..32)
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      request an operation (sampled only in IDLE)
//   sub        0 = a + b, 1 = a - b (sampled with start)
//   a, b       operands (sampled with start)
//   busy       high while bits are being processed
//   done       one-cycle pulse when a new result is valid
//   sum        result of the last completed operation, modulo 2^WIDTH
//   carry_out  final carry; when subtracting, 1 means no borrow (a >= b unsigned)
//   overflow   signed overflow of the last result (only with SERIAL_ADDER_OVF_EN)
//
// Build option: define SERIAL_ADDER_OVF_EN to add the overflow port and its logic.

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_a_q, shift_a_d;
  logic [WIDTH-1:0] shift_b_q, shift_b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             carry_out_q, carry_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // The single full-adder cell.
  logic fa_bit;
  logic fa_carry;

  always_comb begin
    fa_bit   = shift_a_q[0] ^ shift_b_q[0] ^ carry_q;
    fa_carry = (shift_a_q[0] & shift_b_q[0]) |
               (shift_a_q[0] & carry_q) |
               (shift_b_q[0] & carry_q);
  end

  always_comb begin
    state_d     = state_q;
    shift_a_d   = shift_a_q;
    shift_b_d   = shift_b_q;
    res_d       = res_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    busy_d      = busy_q;
    done_d      = done_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d       = ovf_q;
`endif

    case (state_q)
      StIdle: begin
        done_d = 1'b0;
        if (start) begin
          // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
          shift_a_d = a;
          shift_b_d = sub ? ~b : b;
          carry_d   = sub;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = StRun;
        end
      end

      StRun: begin
        carry_d   = fa_carry;
        shift_a_d = {1'b0, shift_a_q[WIDTH-1:1]};
        shift_b_d = {1'b0, shift_b_q[WIDTH-1:1]};
        res_d     = {fa_bit, res_q[WIDTH-1:1]};
        cnt_d     = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          sum_d       = {fa_bit, res_q[WIDTH-1:1]};
          carry_out_d = fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB here; fa_carry is the carry out of it.
          ovf_d       = carry_q ^ fa_carry;
`endif
          busy_d      = 1'b0;
          done_d      = 1'b1;
          state_d     = StDone;
        end
      end

      StDone: begin
        done_d  = 1'b0;
        state_d = StIdle;
      end

      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      shift_a_q   <= '0;
      shift_b_q   <= '0;
      res_q       <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_a_q   <= shift_a_d;
      shift_b_q   <= shift_b_d;
      res_q       <= res_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = carry_out_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder (WIDTH=8 and WIDTH=16).
// Overflow checks are compiled in when SERIAL_ADDER_OVF_EN is defined.

module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       carry_out;

  logic        start16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        busy16;
  logic        done16;
  logic [15:0] sum16;
  logic        carry_out16;

`ifdef SERIAL_ADDER_OVF_EN
  logic overflow;
  logic overflow16;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .overflow  (overflow)
`endif
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start16),
    .sub       (1'b0),
    .a         (a16),
    .b         (b16),
    .busy      (busy16),
    .done      (done16),
    .sum       (sum16),
    .carry_out (carry_out16)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .overflow  (overflow16)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Launch one WIDTH=8 operation from IDLE and watch it for 20 cycles. When glitch_at >= 0
  // a second start (0xAA + 0x55) is pulsed at that sample index, while the DUT is in RUN.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                        input int glitch_at, output int busy_cnt, output int done_at,
                        output int done_cnt, output logic stable);
    logic [7:0] prev;
    prev  = sum;
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    sub   = ts;
    @(posedge clk);
    #1;
    busy_cnt = 0;
    done_at  = -1;
    done_cnt = 0;
    stable   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == glitch_at) begin
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        sub   = 1'b0;
      end else begin
        start = 1'b0;
      end
      if (busy) begin
        busy_cnt++;
        if (sum !== prev) stable = 1'b0;
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int   bc;
    int   da;
    int   dc;
    logic st;
    int   done_seen;

    rst_n   = 1'b0;
    start   = 1'b0;
    sub     = 1'b0;
    a       = '0;
    b       = '0;
    start16 = 1'b0;
    a16     = '0;
    b16     = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum", sum, 8'h00);
    check("rst_carry", carry_out, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", overflow, 1'b0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 0x5A + 0x33 = 0x8D, no carry
    run_op(8'h5A, 8'h33, 1'b0, -1, bc, da, dc, st);
    check("add1_busy_cycles", bc, 8);
    check("add1_done_at", da, 8);
    check("add1_done_pulses", dc, 1);
    check("add1_sum", sum, 8'h8D);
    check("add1_carry", carry_out, 1'b0);

    // 0xFF + 0x01 wraps to 0x00 with carry; 0x8D must hold through RUN
    run_op(8'hFF, 8'h01, 1'b0, -1, bc, da, dc, st);
    check("add2_sum", sum, 8'h00);
    check("add2_carry", carry_out, 1'b1);
    check("add2_sum_stable", st, 1'b1);

    // 0x10 - 0x20 = 0xF0 with borrow; 0x20 - 0x10 = 0x10 without
    run_op(8'h10, 8'h20, 1'b1, -1, bc, da, dc, st);
    check("sub1_sum", sum, 8'hF0);
    check("sub1_carry", carry_out, 1'b0);
    run_op(8'h20, 8'h10, 1'b1, -1, bc, da, dc, st);
    check("sub2_sum", sum, 8'h10);
    check("sub2_carry", carry_out, 1'b1);

    // Reset in the middle of RUN aborts the operation
    start = 1'b1;
    sub   = 1'b0;
    a     = 8'h11;
    b     = 8'h22;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_sum", sum, 8'h00);
    check("abort_carry", carry_out, 1'b0);
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    run_op(8'h03, 8'h04, 1'b0, -1, bc, da, dc, st);
    check("post_rst_sum", sum, 8'h07);
    check("post_rst_done_at", da, 8);

    // A start pulsed during RUN is ignored
    run_op(8'h01, 8'h01, 1'b0, 3, bc, da, dc, st);
    check("ignore_sum", sum, 8'h02);
    check("ignore_done_pulses", dc, 1);
    check("ignore_busy_cycles", bc, 8);

`ifdef SERIAL_ADDER_OVF_EN
    run_op(8'h7F, 8'h01, 1'b0, -1, bc, da, dc, st);
    check("ovf1_sum", sum, 8'h80);
    check("ovf1_ovf", overflow, 1'b1);
    check("ovf1_carry", carry_out, 1'b0);
    run_op(8'h80, 8'h01, 1'b1, -1, bc, da, dc, st);
    check("ovf2_sum", sum, 8'h7F);
    check("ovf2_ovf", overflow, 1'b1);
    check("ovf2_carry", carry_out, 1'b1);
`endif

    // WIDTH=16: 0x1234 + 0x4321 = 0x5555
    start16 = 1'b1;
    a16     = 16'h1234;
    b16     = 16'h4321;
    @(posedge clk);
    #1;
    start16 = 1'b0;
    da = -1;
    for (int i = 0; i < 40; i++) begin
      if (done16 && da < 0) da = i;
      @(posedge clk);
      #1;
    end
    check("w16_done_at", da, 16);
    check("w16_sum", sum16, 16'h5555);
    check("w16_carry", carry_out16, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
    check("w16_ovf", overflow16, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
